// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the CPU data-port to APB bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    // RV32I store width codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    // RV32I load width codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Byte-strobe patterns before lane shifting
    localparam logic [3:0] STRB_NONE = 4'b0000;
    localparam logic [3:0] STRB_B    = 4'b0001;
    localparam logic [3:0] STRB_H    = 4'b0011;
    localparam logic [3:0] STRB_W    = 4'b1111;

    // Read word reported when a slave never answers
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_store_align.sv
// Store lane alignment: replicates store data across lanes, builds byte strobes, flags misalignment.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from the request fields.
module apb_store_align
    import apb_bridge_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    output logic        misalign_o
);

    // Width decode: loads drive no data and no strobes, unknown codes are rejected
    always_comb begin
        pwdata_o   = '0;
        pstrb_o    = STRB_NONE;
        misalign_o = 1'b0;
        if (we_i) begin
            case (func3_i)
                F3_SB: begin
                    pwdata_o = {4{wdata_i[7:0]}};
                    pstrb_o  = STRB_B << addr_lo_i;
                end
                F3_SH: begin
                    pwdata_o   = {2{wdata_i[15:0]}};
                    pstrb_o    = STRB_H << {addr_lo_i[1], 1'b0};
                    misalign_o = addr_lo_i[0];
                end
                F3_SW: begin
                    pwdata_o   = wdata_i;
                    pstrb_o    = STRB_W;
                    misalign_o = |addr_lo_i;
                end
                default: misalign_o = 1'b1;
            endcase
        end else begin
            case (func3_i)
                F3_LB, F3_LBU: misalign_o = 1'b0;
                F3_LH, F3_LHU: misalign_o = addr_lo_i[0];
                F3_LW:         misalign_o = |addr_lo_i;
                default:       misalign_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/apb_data_bridge.sv
// Turns each CPU load/store request into one APB transfer; optional ACCESS timeout under APB_TIMEOUT_EN.
// Latency: req in cycle N -> SETUP N+1, ACCESS N+2, done >= N+3; decode/misalign errors answer in N+1.
// Backpressure: req is ignored while busy; ACCESS waits on PREADY (bounded only with APB_TIMEOUT_EN).
module apb_data_bridge
    import apb_bridge_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = 32'h1000_0000,
    parameter int          SLV_NUM        = 4,
    parameter int          SLV_SIZE_LOG2  = 12,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               we,
    input  logic [2:0]         func3,
    input  logic [31:0]        addr,
    input  logic [31:0]        wData,
    output logic [31:0]        rData,
    output logic               done,
    output logic               err,
    output logic               busy,
    output logic [31:0]        PADDR,
    output logic               PWRITE,
    output logic [SLV_NUM-1:0] PSEL,
    output logic               PENABLE,
    output logic [31:0]        PWDATA,
    output logic [3:0]         PSTRB,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    state_e             state_q, state_d;
    logic [31:0]        paddr_q, paddr_d;
    logic               pwrite_q, pwrite_d;
    logic [SLV_NUM-1:0] psel_q, psel_d;
    logic               penable_q, penable_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic [3:0]         pstrb_q, pstrb_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    logic [31:0]        offset;
    logic [31:0]        slv_idx;
    logic               in_window;
    logic [SLV_NUM-1:0] psel_dec;
    logic [31:0]        al_pwdata;
    logic [3:0]         al_pstrb;
    logic               al_misalign;

    apb_store_align u_align (
        .we_i       (we),
        .func3_i    (func3),
        .addr_lo_i  (addr[1:0]),
        .wdata_i    (wData),
        .pwdata_o   (al_pwdata),
        .pstrb_o    (al_pstrb),
        .misalign_o (al_misalign)
    );

    // Slave decode; the explicit lower-bound test keeps a wrapped offset from aliasing into the window
    always_comb begin
        offset    = addr - ADDR_BASE;
        slv_idx   = offset >> SLV_SIZE_LOG2;
        in_window = (addr >= ADDR_BASE) && (slv_idx < 32'(SLV_NUM));
        psel_dec  = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (slv_idx == 32'(i)) psel_dec[i] = 1'b1;
        end
    end

    // Next-state and output-register logic; done/err are single-cycle pulses
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef APB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!in_window || al_misalign) begin
                        // Rejected without touching the bus
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d  = SETUP;
                        paddr_d  = {addr[31:2], 2'b00};
                        pwrite_d = we;
                        psel_d   = psel_dec;
                        pwdata_d = al_pwdata;
                        pstrb_d  = al_pstrb;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                to_cnt_d  = '0;
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    if (!pwrite_q) rdata_d = PRDATA;
                    err_d     = PSLVERR;
                    done_d    = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                // The counter would reach the limit on this edge: give up on the slave
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d   = TIMEOUT_RDATA;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`endif

    assign rData   = rdata_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = (state_q != IDLE);
    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;

endmodule

// File: tb/tb_apb_data_bridge.sv
// Scoreboard bench for apb_data_bridge: driver pushes expectations, monitor pops on SETUP and on done.
// Latency: n/a.
// Backpressure: slave model inserts per-transfer PREADY wait states.
module tb_apb_data_bridge;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  func3 = 3'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] wData = 32'b0;
    logic [31:0] rData;
    logic        done, err, busy;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [3:0]  PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA = 32'b0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    apb_data_bridge dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .func3(func3), .addr(addr), .wData(wData),
        .rData(rData), .done(done), .err(err), .busy(busy),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] paddr;
        logic        pwrite;
        logic [3:0]  psel;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        int          access_cycles;
    } apb_exp_t;

    typedef struct {
        int          done_cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_exp_t;

    typedef struct {
        int          waitn;
        logic [31:0] rdat;
        logic        err;
    } slv_t;

    apb_exp_t apb_q[$];
    rsp_exp_t rsp_q[$];
    slv_t     slv_q[$];

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl_rdata = 32'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Access size in bytes from the RV32I width code; 0 means unsupported
    function automatic int acc_size(input logic w, input logic [2:0] f3);
        if (w) begin
            case (f3)
                3'd0: return 1;
                3'd1: return 2;
                3'd2: return 4;
                default: return 0;
            endcase
        end
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Reference model: expected bus fields, completion cycle and response for one request issued now
    task automatic push_expect(input logic w, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int waitn, input logic [31:0] prd,
                               input logic sle, input bit expect_done);
        int sz;
        logic [31:0] off;
        bit bad;
        bit tmo;
        apb_exp_t ae;
        rsp_exp_t re;
        slv_t se;
        sz  = acc_size(w, f3);
        off = a - BASE;
        bad = (sz == 0) || (a < BASE) || ((off / 32'd4096) >= 32'd4);
        if (sz != 0 && (a % 32'(sz)) != 0) bad = 1;
        tmo = 0;
`ifdef APB_TIMEOUT_EN
        tmo = (waitn >= 255);
`endif
        if (bad) begin
            re.done_cyc = cyc + 1;
            re.err      = 1'b1;
            re.rdata    = 32'b0;
            mdl_rdata   = 32'b0;
        end else begin
            ae.paddr  = a & 32'hFFFF_FFFC;
            ae.pwrite = w;
            ae.psel   = 4'(1 << (off / 32'd4096));
            if (!w)           ae.pwdata = 32'b0;
            else if (sz == 1) ae.pwdata = 32'(wd[7:0]) * 32'h0101_0101;
            else if (sz == 2) ae.pwdata = 32'(wd[15:0]) * 32'h0001_0001;
            else              ae.pwdata = wd;
            ae.pstrb = w ? 4'(((1 << sz) - 1) << (a % 4)) : 4'b0;
            ae.access_cycles = tmo ? 255 : waitn + 1;
            apb_q.push_back(ae);
            se.waitn = waitn;
            se.rdat  = prd;
            se.err   = sle;
            slv_q.push_back(se);
            if (tmo) begin
                re.done_cyc = cyc + 2 + 255;
                re.err      = 1'b1;
                mdl_rdata   = 32'hDEAD_BEEF;
            end else begin
                re.done_cyc = cyc + 3 + waitn;
                re.err      = sle;
                if (!w) mdl_rdata = prd;
            end
            re.rdata = mdl_rdata;
        end
        if (expect_done) rsp_q.push_back(re);
    endtask

    // Driver: one-cycle request, then wait (bounded) for done; returns in the done cycle
    task automatic xfer(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int waitn, input logic [31:0] prd, input logic sle);
        int n;
        push_expect(w, f3, a, wd, waitn, prd, sle, 1'b1);
        req = 1'b1; we = w; func3 = f3; addr = a; wData = wd;
        @(posedge clk); #1;
        req = 1'b0; addr = $urandom; wData = $urandom;
        n = 0;
        while (!done && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_wait_expired addr=%h got done=0 expected done=1", a);
        end
    endtask

    // Slave model: waits the scripted number of cycles in ACCESS, then answers
    slv_t s_cur;
    int   s_wait;
    initial begin
        s_cur.waitn = 0; s_cur.rdat = 32'b0; s_cur.err = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset || PSEL == 4'b0) begin
                PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
            end else if (!PENABLE) begin
                if (slv_q.size() > 0) s_cur = slv_q.pop_front();
                else begin s_cur.waitn = 0; s_cur.rdat = 32'b0; s_cur.err = 1'b0; end
                s_wait = s_cur.waitn;
                PREADY = 1'b0; PRDATA = $urandom;
            end else if (s_wait > 0) begin
                s_wait--;
                PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
            end else begin
                PREADY = 1'b1; PRDATA = s_cur.rdat; PSLVERR = s_cur.err;
            end
        end
    end

    // Monitor: compares bus fields at SETUP, hold during ACCESS, response at done
    apb_exp_t m_cur;
    rsp_exp_t m_rsp;
    int       m_acc = 0;
    bit       m_in_xfer = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_in_xfer = 0;
            end else begin
                if (done) begin
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
                    end else begin
                        m_rsp = rsp_q.pop_front();
                        chk("done_cycle", 32'(cyc), 32'(m_rsp.done_cyc));
                        chk("err", 32'(err), 32'(m_rsp.err));
                        chk("rdata", rData, m_rsp.rdata);
                        chk("busy_at_done", 32'(busy), 32'd0);
                    end
                end
                if (PSEL != 4'b0 && !PENABLE) begin
                    if (apb_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_psel at cycle %0d: got PSEL=%b expected 0000", cyc, PSEL);
                    end else begin
                        m_cur = apb_q.pop_front();
                        chk("paddr", PADDR, m_cur.paddr);
                        chk("pwrite", 32'(PWRITE), 32'(m_cur.pwrite));
                        chk("psel", 32'(PSEL), 32'(m_cur.psel));
                        chk("pwdata", PWDATA, m_cur.pwdata);
                        chk("pstrb", 32'(PSTRB), 32'(m_cur.pstrb));
                        chk("busy_in_setup", 32'(busy), 32'd1);
                        m_acc = 0;
                        m_in_xfer = 1;
                    end
                end else if (PSEL != 4'b0 && PENABLE) begin
                    m_acc++;
                    chk("apb_hold", 32'(PADDR === m_cur.paddr && PSEL === m_cur.psel &&
                                        PWDATA === m_cur.pwdata && PSTRB === m_cur.pstrb &&
                                        PWRITE === m_cur.pwrite), 32'd1);
                end else if (m_in_xfer) begin
                    chk("access_cycles", 32'(m_acc), 32'(m_cur.access_cycles));
                    m_in_xfer = 0;
                end
            end
        end
    end

    // Stimulus
    logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    initial begin
        int n;
        logic w;
        logic [2:0] f3;
        logic [31:0] a;
        #2 reset = 1'b0;
        #1;
        chk("reset_rdata", rData, 32'd0);
        chk("reset_ctrl", 32'({done, err, busy, PWRITE, PENABLE}), 32'd0);
        chk("reset_paddr", PADDR, 32'd0);
        chk("reset_pwdata", PWDATA, 32'd0);
        chk("reset_sel_strb", 32'({PSEL, PSTRB}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        xfer(1'b1, 3'd2, 32'h1000_1004, 32'hCAFE_F00D, 0, 32'h0, 1'b0);
        xfer(1'b1, 3'd0, 32'h1000_0003, 32'h0000_00A5, 0, 32'h0, 1'b0);
        xfer(1'b1, 3'd1, 32'h1000_2002, 32'h0000_BEEF, 1, 32'h0, 1'b0);
        xfer(1'b0, 3'd2, 32'h1000_3008, 32'h0, 4, 32'h1234_5678, 1'b0);
        xfer(1'b0, 3'd1, 32'h1000_0001, 32'h0, 0, 32'h0, 1'b0);
        xfer(1'b1, 3'd2, 32'h0FFF_FFFC, 32'h1111_2222, 0, 32'h0, 1'b0);
        xfer(1'b0, 3'd0, 32'h1000_3FFF, 32'h0, 2, 32'h89AB_CDEF, 1'b1);
        xfer(1'b1, 3'd0, 32'h1000_4000, 32'h5A, 0, 32'h0, 1'b0);
        xfer(1'b1, 3'd3, 32'h1000_0000, 32'h5A, 0, 32'h0, 1'b0);

        // Randomized mix, back-to-back with occasional idle gaps
        for (int i = 0; i < 80; i++) begin
            w  = 1'($urandom % 2);
            if (w) f3 = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
            else   f3 = ld_codes[$urandom % 5];
            a = BASE + ($urandom % 5) * 32'd4096 + ($urandom % 4096);
            if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
            if ($urandom % 10 == 0) a = $urandom % BASE;
            xfer(w, f3, a, $urandom, int'($urandom % 4), $urandom, 1'($urandom % 8 == 0));
            if ($urandom % 3 == 0) begin
                n = int'($urandom % 3);
                repeat (n) begin @(posedge clk); #1; end
            end
        end

`ifdef APB_TIMEOUT_EN
        xfer(1'b0, 3'd2, 32'h1000_2010, 32'h0, 100000, 32'h0, 1'b0);
`endif

        // Reset while in ACCESS: outputs clear at once and no done follows
        push_expect(1'b0, 3'd2, 32'h1000_1010, 32'h0, 20, 32'h7777_7777, 1'b0, 1'b0);
        req = 1'b1; we = 1'b0; func3 = 3'd2; addr = 32'h1000_1010;
        @(posedge clk); #1;
        req = 1'b0;
        n = 0;
        while (!PENABLE && n < 10) begin @(posedge clk); #1; n++; end
        chk("reached_access", 32'(PENABLE), 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("async_reset_rdata", rData, 32'd0);
        chk("async_reset_ctrl", 32'({done, err, busy, PWRITE, PENABLE}), 32'd0);
        chk("async_reset_paddr", PADDR, 32'd0);
        chk("async_reset_sel_strb", 32'({PSEL, PSTRB}), 32'd0);
        apb_q.delete(); rsp_q.delete(); slv_q.delete();
        mdl_rdata = 32'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_done_in_reset", 32'(done), 32'd0);
        end
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_done_after_reset", 32'(done), 32'd0);
        end
        xfer(1'b0, 3'd4, 32'h1000_0002, 32'h0, 0, 32'hFFFF_FF80, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("apb_queue_drained", 32'(apb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog_expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_data_bridge.md
Name: apb_data_bridge

Overview:
- Sits directly downstream of the CPU datapath's data-memory port: consumes busAddr/busWData/func3 plus a request strobe from the control unit, and turns each load/store into one APB transaction.
- Produces a registered raw 32-bit read word for the load-extract logic and a one-cycle done pulse that the control unit uses to release its stall.
- Performs store lane alignment, byte strobes, and slave-select decode.

Parameters:
- ADDR_BASE, 32'h1000_0000, base address of the peripheral window.
- SLV_NUM, 4, number of APB slaves (PSEL width).
- SLV_SIZE_LOG2, 12, log2 of bytes per slave region.
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  transfer request, sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- func3  in  3  RV32I width code: SB/SH/SW or LB/LH/LW/LBU/LHU.
- addr  in  32  byte address (busAddr).
- wData  in  32  store data, unaligned (busWData).
- rData  out  32  captured PRDATA word, unextracted.
- done  out  1  one-cycle pulse when the transfer completes.
- err  out  1  valid with done; decode, misalign, PSLVERR, or timeout.
- busy  out  1  high in SETUP/ACCESS.
- PADDR  out  32  APB address, word-aligned ({addr[31:2],2'b00}).
- PWRITE  out  1  APB direction.
- PSEL  out  SLV_NUM  one-hot slave select.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  lane-replicated store data.
- PSTRB  out  4  byte strobes (all zero on reads).
- PRDATA  in  32  muxed slave read data.
- PREADY  in  1  muxed slave ready.
- PSLVERR  in  1  muxed slave error.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs 0: rData, done, err, busy, PADDR, PWRITE, PSEL, PENABLE, PWDATA, PSTRB.
- A reset mid-transfer aborts immediately; no done is produced.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, req=1: register addr, we, the aligned write data, and the strobe.
  - Address decode: idx = (addr-ADDR_BASE)>>SLV_SIZE_LOG2.
  - Out of window (addr<ADDR_BASE, or idx>=SLV_NUM): stay in IDLE; next cycle done=1, err=1, rData=0. No PSEL is asserted.
  - Misaligned (SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0): same response as out-of-window.
  - Otherwise go to SETUP.
- SETUP: PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB valid and held stable. Always goes to ACCESS the next cycle.
- ACCESS: PENABLE=1, all APB outputs held.
  - On PREADY=1: rData<=PRDATA (loads only; stores leave rData unchanged), err<=PSLVERR. Next cycle done=1, PSEL=0, PENABLE=0, state=IDLE.
- Latency: req in cycle N gives SETUP in N+1, ACCESS in N+2, and done at the earliest in N+3 (zero-wait slave).
- req is ignored while busy.
- A req coincident with done is accepted (state is IDLE in that cycle), so back-to-back transfers take 3 cycles each.
- Store alignment:
  - SB: PWDATA={4{wData[7:0]}}, PSTRB=4'b0001<<addr[1:0].
  - SH: PWDATA={2{wData[15:0]}}, PSTRB=4'b0011<<{addr[1],1'b0}.
  - SW: PWDATA=wData, PSTRB=4'b1111.
- Loads: PSTRB=0, PWDATA=0.
- Unknown func3 for a store is treated as misaligned (err).
- Address arithmetic is 32-bit unsigned. Wrap-around of addr-ADDR_BASE is prevented by the explicit addr<ADDR_BASE check.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: an 8-bit-minimum counter clears on entry to ACCESS and increments each ACCESS cycle without PREADY.
  - When it reaches TIMEOUT_CYCLES: abort, drop PSEL/PENABLE, rData<=32'hDEAD_BEEF, then done=1, err=1 next cycle.
  - PREADY arriving in the same cycle as expiry wins (normal completion).
- Undefined: no counter; ACCESS waits for PREADY indefinitely.

Decomposition:
- Package apb_bridge_pkg:
  - state enum (IDLE, SETUP, ACCESS).
  - func3 constants (SB, SH, SW, LB, LH, LW, LBU, LHU).
  - PSTRB constants.
- Sub-module apb_store_align: combinational; inputs func3, addr[1:0], wData; outputs PWDATA, PSTRB, misalign flag.
- The FSM, decode, and optional timeout stay in the top module.

Test Plan:
- SW 32'hCAFE_F00D to 32'h1000_1004 with a zero-wait slave -> PSEL=4'b0010, PSTRB=4'b1111, PADDR=32'h1000_1004; done exactly 3 cycles after req, err=0.
- SB wData=32'h0000_00A5 at 32'h1000_0003 -> PWDATA=32'hA5A5_A5A5, PSTRB=4'b1000.
- SH at 32'h1000_2002 -> PWDATA={2{wData[15:0]}}, PSTRB=4'b1100.
- LW at 32'h1000_3008, slave holds PREADY low 4 cycles then returns 32'h1234_5678 -> PENABLE held 5 cycles, rData=32'h1234_5678, done after 7 cycles.
- LH at 32'h1000_0001, and SW at 32'h0FFF_FFFC -> no PSEL; done=1, err=1 one cycle after req; rData=0.
- reset=0 during ACCESS -> all outputs 0 asynchronously and no done.
- With APB_TIMEOUT_EN and PREADY stuck low -> done=1, err=1, rData=32'hDEAD_BEEF.
